divider_bank: RTL and testbench



---
 rtl/divider_pkg.sv | 19 +
 rtl/divider_channel.sv | 121 ++++++++++++
 rtl/divider_bank.sv | 51 +++++
 tb/tb_divider_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared constants and ratio helpers for the divider_bank channels.
package divider_pkg;

    localparam int MAX_CH = 16;

    // Ratios below 2 cannot produce a square wave, so they run as divide-by-2.
    function automatic int unsigned eff_div(input int unsigned d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

    // Legacy cascade default: channel ch divides by 2^(ch+1), wrapped to cnt_w bits.
    function automatic int unsigned reset_div(input int ch, input int cnt_w);
        if ((ch + 1) >= cnt_w || (ch + 1) >= 32) begin
            return 32'd0;
        end
        return 32'd1 << (ch + 1);
    endfunction

endpackage

// File: rtl/divider_channel.sv
// divider_channel: one programmable clock-enable divider with a shadowed ratio.
// The end-of-period tick flop exists only when DIVIDER_TICK_EN is defined.
module divider_channel
    import divider_pkg::*;
#(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic             i_wr_en,
    input  logic [CNT_W-1:0] i_wr_div,
    output logic             o_pend,
    output logic             o_div,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_a;
    logic [CNT_W-1:0] r_div_s;
    logic             r_pend;
    logic             r_en;
    logic             r_div;

    logic [CNT_W-1:0] w_de;
    logic             w_wrap;
    logic [CNT_W-1:0] w_cnt_n;
    logic [CNT_W-1:0] w_div_a_n;
    logic [CNT_W-1:0] w_div_s_n;
    logic             w_pend_n;
    logic             w_en_n;
    logic [CNT_W-1:0] w_de_n;
    logic [CNT_W-1:0] w_h_n;
    logic             w_div_n;

    assign w_de   = CNT_W'(eff_div(32'(r_div_a)));
    assign w_wrap = r_en && (r_cnt == w_de - CNT_W'(1));

    // Counting first, then the accepted write; a write on the wrap edge
    // therefore arms the shadow for the period after the one just starting.
    always_comb begin
        w_cnt_n   = r_cnt;
        w_div_a_n = r_div_a;
        w_div_s_n = r_div_s;
        w_pend_n  = r_pend;
        w_en_n    = r_en;
        if (r_en) begin
            if (w_wrap) begin
                w_cnt_n = '0;
                if (r_pend) begin
                    w_div_a_n = r_div_s;
                    w_pend_n  = 1'b0;
                end
            end else begin
                w_cnt_n = r_cnt + CNT_W'(1);
            end
        end
        if (i_wr) begin
            if (!i_wr_en) begin
                w_en_n    = 1'b0;
                w_cnt_n   = '0;
                w_pend_n  = 1'b0;
                w_div_a_n = i_wr_div;
            end else if (!r_en) begin
                w_en_n    = 1'b1;
                w_cnt_n   = '0;
                w_div_a_n = i_wr_div;
            end else begin
                w_div_s_n = i_wr_div;
                w_pend_n  = 1'b1;
            end
        end
    end

    // Outputs are registered from next-state values so they line up with r_cnt.
    assign w_de_n  = CNT_W'(eff_div(32'(w_div_a_n)));
    assign w_h_n   = w_de_n >> 1;
    assign w_div_n = w_en_n && (w_cnt_n >= (w_de_n - w_h_n));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_div_a <= RST_DIV;
            r_div_s <= RST_DIV;
            r_pend  <= 1'b0;
            r_en    <= 1'b1;
            r_div   <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_n;
            r_div_a <= w_div_a_n;
            r_div_s <= w_div_s_n;
            r_pend  <= w_pend_n;
            r_en    <= w_en_n;
            r_div   <= w_div_n;
        end
    end

`ifdef DIVIDER_TICK_EN
    logic r_tick;
    logic w_tick_n;

    assign w_tick_n = w_en_n && (w_cnt_n == w_de_n - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick_n;
        end
    end

    assign o_tick = r_tick;
`else
    assign o_tick = 1'b0;
`endif

    assign o_pend = r_pend;
    assign o_div  = r_div;

endmodule

// File: rtl/divider_bank.sv
// divider_bank: N_CH programmable clock-enable dividers behind one config port.
// Define DIVIDER_TICK_EN to build the per-channel end-of-period tick strobes.
module divider_bank
    import divider_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int CNT_W = 16,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
    output logic [N_CH-1:0]  div_out,
    output logic [N_CH-1:0]  tick_out
);

    logic [N_CH-1:0] w_pend;
    logic [N_CH-1:0] w_wr;
    logic            w_ch_ok;
    logic            w_accept;

    // Handshake: a write transfers on any edge where cfg_valid && cfg_ready.
    // cfg_ready drops only while the addressed channel holds an unapplied
    // ratio; writes to channels beyond N_CH are always taken and dropped.
    assign w_ch_ok   = (int'(cfg_ch) < N_CH);
    assign cfg_ready = w_ch_ok ? !w_pend[cfg_ch] : 1'b1;
    assign w_accept  = cfg_valid && cfg_ready;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign w_wr[gi] = w_accept && w_ch_ok && (int'(cfg_ch) == gi);

        divider_channel #(
            .CNT_W   (CNT_W),
            .RST_DIV (CNT_W'(reset_div(gi, CNT_W)))
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_wr     (w_wr[gi]),
            .i_wr_en  (cfg_en),
            .i_wr_div (cfg_div),
            .o_pend   (w_pend[gi]),
            .o_div    (div_out[gi]),
            .o_tick   (tick_out[gi])
        );
    end

endmodule

// File: tb/tb_divider_bank.sv
// tb_divider_bank: randomized config writes against a period-queue reference
// model; outputs and cfg_ready are scored every cycle.
module tb_divider_bank;

    localparam int N_CH  = 8;
    localparam int CNT_W = 16;
    localparam int CH_W  = $clog2(N_CH);
`ifdef DIVIDER_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch    = '0;
    logic [CNT_W-1:0] cfg_div   = '0;
    logic             cfg_en    = 1'b0;
    logic [N_CH-1:0]  div_out;
    logic [N_CH-1:0]  tick_out;

    int total = 0;
    int bad   = 0;

    divider_bank #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .div_out   (div_out),
        .tick_out  (tick_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each enabled channel owns a queue holding the rest of its current period,
    // one {tick, div} entry per cycle; the front is what the outputs show now.
    logic [1:0]           m_wave [N_CH][$];
    bit                   m_en   [N_CH];
    bit                   m_pend [N_CH];
    int unsigned          m_ratio[N_CH];
    int unsigned          m_next [N_CH];
    bit                   m_acc;
    int                   m_acc_cnt = 0;
    logic [2*N_CH-1:0]    exp_q[$];

    function automatic int unsigned rst_ratio(input int ch);
        if (ch + 1 >= CNT_W) return 0;
        return 32'd1 << (ch + 1);
    endfunction

    function automatic void fill_period(input int ch, input int unsigned d);
        int unsigned de;
        int unsigned hi;
        de = (d < 2) ? 2 : d;
        hi = de / 2;
        for (int unsigned k = 0; k < de - hi; k++) m_wave[ch].push_back(2'b00);
        for (int unsigned k = 0; k < hi; k++) begin
            if (k == hi - 1) m_wave[ch].push_back({TICK_ON, 1'b1});
            else             m_wave[ch].push_back(2'b01);
        end
    endfunction

    function automatic bit exp_ready(input logic [CH_W-1:0] ch);
        if (int'(ch) >= N_CH) return 1'b1;
        return !m_pend[int'(ch)];
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        for (int i = 0; i < N_CH; i++) begin
            m_en[i]    = 1'b1;
            m_pend[i]  = 1'b0;
            m_ratio[i] = rst_ratio(i);
            m_next[i]  = 0;
            m_wave[i].delete();
            fill_period(i, m_ratio[i]);
        end
    endfunction

    function automatic void apply_write(input int ch, input int unsigned d, input bit en);
        if (!en) begin
            m_en[ch]    = 1'b0;
            m_pend[ch]  = 1'b0;
            m_ratio[ch] = d;
            m_wave[ch].delete();
        end else if (!m_en[ch]) begin
            m_en[ch]    = 1'b1;
            m_ratio[ch] = d;
            m_wave[ch].delete();
            fill_period(ch, d);
        end else begin
            m_next[ch] = d;
            m_pend[ch] = 1'b1;
        end
    endfunction

    function automatic logic [2*N_CH-1:0] expected_outputs();
        logic [N_CH-1:0] d;
        logic [N_CH-1:0] t;
        d = '0;
        t = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (m_en[i]) begin
                d[i] = m_wave[i][0][0];
                t[i] = m_wave[i][0][1];
            end
        end
        return {d, t};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_acc = cfg_valid && exp_ready(cfg_ch);
            for (int i = 0; i < N_CH; i++) begin
                if (m_en[i]) begin
                    void'(m_wave[i].pop_front());
                    if (m_wave[i].size() == 0) begin
                        if (m_pend[i]) begin
                            m_ratio[i] = m_next[i];
                            m_pend[i]  = 1'b0;
                        end
                        fill_period(i, m_ratio[i]);
                    end
                end
            end
            if (m_acc) begin
                m_acc_cnt++;
                if (int'(cfg_ch) < N_CH) apply_write(int'(cfg_ch), 32'(cfg_div), cfg_en);
            end
            exp_q.push_back(expected_outputs());
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [2*N_CH-1:0] e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({div_out, tick_out} !== e) begin
                bad++;
                $display("FAIL outputs t=%0t: div_out=%b tick_out=%b required div_out=%b tick_out=%b",
                         $time, div_out, tick_out, e[2*N_CH-1:N_CH], e[N_CH-1:0]);
            end
        end
    end

    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            total++;
            if (cfg_ready !== exp_ready(cfg_ch)) begin
                bad++;
                $display("FAIL cfg_ready t=%0t ch=%0d: got %b required %b",
                         $time, cfg_ch, cfg_ready, exp_ready(cfg_ch));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cfg_ch = CH_W'($urandom_range(0, N_CH - 1));
            @(negedge clk);
        end
    endtask

    task automatic cfg_write(input int ch, input int unsigned d, input bit en);
        int start;
        int n;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(d);
        cfg_en    = en;
        cfg_valid = 1'b1;
        start     = m_acc_cnt;
        n         = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_acc_cnt == start && n < 300);
        cfg_valid = 1'b0;
        if (m_acc_cnt == start) begin
            total++;
            bad++;
            $display("FAIL write_timeout ch=%0d: accepted=0 required=1", ch);
        end
    endtask

    task automatic wait_until_left(input int ch, input int left);
        int n;
        n = 0;
        while (!(m_en[ch] && m_wave[ch].size() == left)) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                total++;
                bad++;
                $display("FAIL wait_phase ch=%0d: left=%0d required=%0d", ch, m_wave[ch].size(), left);
                return;
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (div_out !== '0 || tick_out !== '0) begin
            bad++;
            $display("FAIL %s: div_out=%b tick_out=%b required all zero", name, div_out, tick_out);
        end
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: got %b required 1", name, cfg_ready);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset_state");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Legacy cascade defaults.
        idle(40);

        // Ratio change mid-period on ch1, then a second write held while pending.
        wait_until_left(1, 3);
        cfg_write(1, 5, 1'b1);
        cfg_write(1, 3, 1'b1);
        idle(30);

        // Degenerate ratios behave as 2.
        cfg_write(3, 0, 1'b1);
        idle(12);
        cfg_write(3, 1, 1'b1);
        idle(12);

        // Disable ch4 in its high phase, then re-enable with D=6.
        wait_until_left(4, 8);
        cfg_write(4, 7, 1'b0);
        idle(5);
        cfg_write(4, 6, 1'b1);
        idle(20);

        // Randomized traffic.
        for (int k = 0; k < 150; k++) begin
            idle($urandom_range(0, 3));
            cfg_write($urandom_range(0, N_CH - 1), $urandom_range(0, 10),
                      ($urandom_range(0, 5) != 0));
        end
        idle(20);

        // Asynchronous reset in the middle of activity.
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_hold");
        #1 rst_n = 1'b1;
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
